// File: rtl/zero_event_counter.sv
// Counts rising edges of the upstream zero-state flag Y as 4-digit BCD, with a registered
// seven-segment display copy. Define DISPLAY_HOLD_EN to let HOLD freeze the display.
`timescale 1ns/1ps

module zero_event_counter #(
  parameter int unsigned SAT = 0
) (
  input  logic        CLK,
  input  logic        R,
  input  logic        Y,
  input  logic        CLR,
  input  logic        HOLD,
  output logic [15:0] Count,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic        OVF
);

  logic        yd_q, yd_d;
  logic [15:0] count_q, count_d;
  logic [15:0] disp_q, disp_d;
  logic        ovf_q, ovf_d;
  logic [15:0] count_inc;
  logic        carry;
  logic        rise;

  assign rise = Y & ~yd_q;

  // Ripple BCD increment; carry survives only when every digit was 9.
  always_comb begin
    count_inc = count_q;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_comb begin
    yd_d    = Y;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (CLR) begin
      count_d = 16'h0000;
      ovf_d   = 1'b0;
    end else if (rise) begin
      if (carry) begin
        ovf_d   = 1'b1;
        count_d = (SAT != 0) ? count_q : 16'h0000;
      end else begin
        count_d = count_inc;
      end
    end
  end

`ifdef DISPLAY_HOLD_EN
  always_comb begin
    if (CLR) begin
      disp_d = 16'h0000;
    end else if (HOLD) begin
      disp_d = disp_q;
    end else begin
      disp_d = count_d;
    end
  end
`else
  logic unused_hold;
  assign unused_hold = HOLD;
  assign disp_d      = count_d;
`endif

  // Yd resets high so the upstream reset state (Y=1) is not seen as a rise.
  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      yd_q    <= 1'b1;
      count_q <= 16'h0000;
      disp_q  <= 16'h0000;
      ovf_q   <= 1'b0;
    end else begin
      yd_q    <= yd_d;
      count_q <= count_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign Count = count_q;
  assign OVF   = ovf_q;
  assign HEX0  = seg7(disp_q[3:0]);
  assign HEX1  = seg7(disp_q[7:4]);
  assign HEX2  = seg7(disp_q[11:8]);
  assign HEX3  = seg7(disp_q[15:12]);

endmodule

// File: tb/tb_zero_event_counter.sv
// Scoreboard bench for zero_event_counter: a wrapping and a saturating instance share stimulus;
// expectations come from an integer event-count model and are checked by a negedge monitor.
`timescale 1ns/1ps

module tb_zero_event_counter;

  logic        CLK = 1'b0;
  logic        R   = 1'b1;
  logic        Y   = 1'b1;
  logic        CLR = 1'b0;
  logic        HOLD = 1'b0;
  logic [15:0] count_w, count_s;
  logic [6:0]  h0_w, h1_w, h2_w, h3_w, h0_s, h1_s, h2_s, h3_s;
  logic        ovf_w, ovf_s;

  zero_event_counter #(.SAT(0)) u_wrap (
    .CLK(CLK), .R(R), .Y(Y), .CLR(CLR), .HOLD(HOLD), .Count(count_w),
    .HEX0(h0_w), .HEX1(h1_w), .HEX2(h2_w), .HEX3(h3_w), .OVF(ovf_w)
  );

  zero_event_counter #(.SAT(1)) u_sat (
    .CLK(CLK), .R(R), .Y(Y), .CLR(CLR), .HOLD(HOLD), .Count(count_s),
    .HEX0(h0_s), .HEX1(h1_s), .HEX2(h2_s), .HEX3(h3_s), .OVF(ovf_s)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int cnt [2];
    int disp [2];
    bit ovf [2];
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Reference state: plain integers, index 0 = wrapping, 1 = saturating.
  int m_cnt [2];
  int m_disp [2];
  bit m_ovf [2];
  bit m_yd;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [27:0] hex_of(input int v);
    return {seg_of(v / 1000 % 10), seg_of(v / 100 % 10), seg_of(v / 10 % 10), seg_of(v % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  task automatic model(input bit r, input bit y, input bit clr, input bit hold);
    bit rise;
    if (r) begin
      m_yd = 1'b1;
      for (int s = 0; s < 2; s++) begin
        m_cnt[s] = 0; m_disp[s] = 0; m_ovf[s] = 1'b0;
      end
    end else begin
      rise = y && !m_yd;
      m_yd = y;
      for (int s = 0; s < 2; s++) begin
        if (clr) begin
          m_cnt[s] = 0; m_ovf[s] = 1'b0;
        end else if (rise) begin
          if (m_cnt[s] == 9999) begin
            m_ovf[s] = 1'b1;
            m_cnt[s] = (s == 1) ? 9999 : 0;
          end else begin
            m_cnt[s] = m_cnt[s] + 1;
          end
        end
`ifdef DISPLAY_HOLD_EN
        if (clr) m_disp[s] = 0;
        else if (!hold) m_disp[s] = m_cnt[s];
`else
        m_disp[s] = m_cnt[s];
`endif
      end
    end
  endtask

  // One clock: drive inputs, advance the model, queue what the DUT must show after the edge.
  task automatic cyc(input bit y, input bit clr, input bit hold);
    exp_t e;
    Y = y; CLR = clr; HOLD = hold;
    model(R, y, clr, hold);
    e.cnt = m_cnt; e.disp = m_disp; e.ovf = m_ovf;
    @(posedge CLK);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic rises(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count_wrap", 32'(count_w), 32'(to_bcd(e.cnt[0])));
        check("hex_wrap", 32'({h3_w, h2_w, h1_w, h0_w}), 32'(hex_of(e.disp[0])));
        check("ovf_wrap", 32'(ovf_w), 32'(e.ovf[0]));
        check("count_sat", 32'(count_s), 32'(to_bcd(e.cnt[1])));
        check("hex_sat", 32'({h3_s, h2_s, h1_s, h0_s}), 32'(hex_of(e.disp[1])));
        check("ovf_sat", 32'(ovf_s), 32'(e.ovf[1]));
      end
    end
  end

  initial begin : driver
    // Reset with Y held high, then release: the held-high Y must not count.
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    R = 1'b0;
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    // 0,1,1,1,0,1 -> two events.
    cyc(1'b0, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0); cyc(1'b0, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0);
    // Digit carry 0009 -> 0010.
    cyc(1'b0, 1'b1, 1'b0);
    rises(10);
    // CLR beats a same-cycle rise at 0005.
    cyc(1'b0, 1'b1, 1'b0);
    rises(5);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    // Display freeze at 0004 across three rises, then release.
    cyc(1'b0, 1'b1, 1'b0);
    rises(4);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b1);
    end
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    // Full range: wrap vs saturate, overflow sticky, then clear.
    rises(10000);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    rises(3);
    cyc(1'b0, 1'b1, 1'b0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)));
    end
    // Asynchronous reset mid-count must clear without a clock edge.
    rises(7);
    @(negedge CLK);
    #1;
    R = 1'b1;
    #1;
    check("async_rst_count_wrap", 32'(count_w), 32'h0);
    check("async_rst_count_sat", 32'(count_s), 32'h0);
    check("async_rst_hex0", 32'(h0_w), 32'(7'b1000000));
    check("async_rst_ovf", 32'(ovf_s), 32'h0);
    model(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    R = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    rises(2);
    @(negedge CLK);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/zero_event_counter.md
ZERO_EVENT_COUNTER -- requirements
Module: zero_event_counter

Interface
REQ-001 SHALL have parameter SAT, default 0; 0 = count wraps 9999->0000, 1 = count saturates at 9999.
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on posedge CLK.
REQ-003 SHALL have port R, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port Y, input, 1, the zero-state flag from the upstream mod-5 state machine, synchronous to CLK.
REQ-005 SHALL have port CLR, input, 1, synchronous clear of count, display and overflow.
REQ-006 SHALL have port HOLD, input, 1, display freeze request (see REQ-022).
REQ-007 SHALL have port Count, output, 16, live count as 4 BCD digits; [3:0] = ones, [15:12] = thousands.
REQ-008 SHALL have ports HEX0..HEX3, output, 7 each, active-low seven-segment digits (bit6 = g ... bit0 = a); HEX0 = ones.
REQ-009 SHALL have port OVF, output, 1, sticky flag set when the count passes 9999.

Function
REQ-010 SHALL register Y into Yd every cycle; rise = Y & ~Yd.
REQ-011 SHALL increment Count by one BCD step on the edge where rise is sampled; Count shows the new value one cycle after Y first reads high.
REQ-012 SHALL carry per digit: a digit at 9 goes to 0 and increments the next digit; no digit ever holds A-F.
REQ-013 SHALL count a Y held high for N cycles as one event; Y must drop low and rise again to count again.
REQ-014 SHALL, with SAT=0, make a rise at 9999 produce 0000 and set OVF.
REQ-015 SHALL, with SAT=1, make a rise at 9999 leave Count at 9999 and set OVF.
REQ-016 SHALL hold OVF at 1 until CLR or R.
REQ-017 SHALL give CLR priority over rise in the same cycle: Count=0000, OVF=0, the event is dropped, and Yd still updates.
REQ-018 SHALL keep a display register Disp (16 bits) that loads the next value of Count each cycle unless frozen.
REQ-019 SHALL decode HEX0..HEX3 combinationally from Disp; digit 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000.
REQ-020 SHALL never make Count change by more than one step per cycle.

Reset
REQ-021 SHALL, while R=1, force Count=0000, Disp=0000, OVF=0 and Yd=1, so the upstream reset state (Y=1) is not counted; HEX0..3 = 7'b1000000. Asserting R mid-count discards the count immediately, without waiting for CLK.

Configuration
REQ-022 SHALL use macro DISPLAY_HOLD_EN to control display freeze.
- Macro defined: while HOLD=1, Disp keeps its value and counting continues in Count. On the first cycle with HOLD=0, Disp reloads the current Count. CLR clears Disp even when HOLD=1.
- Macro undefined: HOLD is ignored and Disp tracks Count every cycle; the port is still present.

Verification
REQ-023 SHALL cover: reset with Y=1 held, then 3 cycles -> Count=0000, HEX0=7'b1000000, OVF=0.
REQ-024 SHALL cover: Y pattern 0,1,1,1,0,1 -> Count=0001 after first rise and 0002 after second; held-high cycles add nothing.
REQ-025 SHALL cover: preload to 0009 via 9 rises, 1 more rise -> Count=0010, HEX1=7'b1111001, HEX0=7'b1000000.
REQ-026 SHALL cover: 10000 rises -> SAT=0: Count=0000, OVF=1; SAT=1: Count=9999, OVF=1. CLR -> both 0000, OVF=0.
REQ-027 SHALL cover: CLR and rise in the same cycle at Count=0005 -> Count=0000 next cycle.
REQ-028 SHALL cover: DISPLAY_HOLD_EN defined, HOLD=1 at 0004, 3 rises -> Count=0007, HEX0 still shows 4; HOLD=0 -> HEX0 shows 7 next cycle.
